fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_seq.sv | 104 ++++++++++
 tb/tb_fp_mul_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// Sequential signed fixed-point multiplier: one shift-add step per cycle over |a|*|b|,
// then truncation toward zero and saturation to the signed Q-format range.
module fp_mul_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned Q     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned      CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinSat = ~MaxPos + WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state;
    logic               sign;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [CntW-1:0]    cnt;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mag;
    logic               ovf_next;
    logic [WIDTH-1:0]   res_next;

    // The most-negative operand negates to itself, which is exactly 2^(WIDTH-1) unsigned.
    always_comb begin
        abs_a    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        abs_b    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        acc_next = acc;
        if (mag_b[cnt]) begin
            acc_next = acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
        end
        mag      = acc_next[WIDTH+Q-1:Q];
        ovf_next = |acc_next[2*WIDTH-1:WIDTH+Q-1];
        if (ovf_next) begin
            res_next = sign ? MinSat : MaxPos;
        end else begin
            res_next = sign ? (~mag + WIDTH'(1)) : mag;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= StIdle;
            sign     <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= StCalc;
                    end
                end
                StCalc: begin
                    acc <= acc_next;
                    cnt <= cnt + CntW'(1);
                    // Result is formed from the final step's sum so it is valid on DONE entry.
                    if (cnt == CntW'(WIDTH - 1)) begin
                        result   <= res_next;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: the driver queues hand-computed results, the monitor
// pops and compares them on every done pulse.
module tb_fp_mul_seq;

    localparam int NV = 13;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    fp_mul_seq #(
        .WIDTH(32),
        .Q    (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] r;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   period_chk = 1'b0;
    int   last_done = -1;

    // Operands and hand-computed Q16 products (truncate toward zero, saturate).
    logic [31:0] va [NV] = '{32'h00020000, 32'hFFFE8000, 32'hFFFFFFFF, 32'h40000000,
                             32'h80000000, 32'h00010000, 32'h80000000, 32'h00008000,
                             32'hFFFF0000, 32'h7FFFFFFF, 32'h80000000, 32'h00000001,
                             32'hFFFF8000};
    logic [31:0] vb [NV] = '{32'h00030000, 32'h00020000, 32'h00008000, 32'h00040000,
                             32'h00020000, 32'h00010000, 32'hFFFF0000, 32'h00008000,
                             32'hFFFF0000, 32'h00010000, 32'h00010000, 32'h00000001,
                             32'h00000003};
    logic [31:0] vr [NV] = '{32'h00060000, 32'hFFFD0000, 32'h00000000, 32'h7FFFFFFF,
                             32'h80000001, 32'h00010000, 32'h7FFFFFFF, 32'h00004000,
                             32'h00010000, 32'h7FFFFFFF, 32'h80000001, 32'h00000000,
                             32'hFFFFFFFF};
    logic        vo [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0};

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] r, input logic o);
        exp_t e;
        e.r = r;
        e.o = o;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=result %h expected=no done", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.r);
                check("overflow", 32'(overflow), 32'(e.o));
            end
            if (period_chk && last_done >= 0) check("b2b_period", 32'(cyc - last_done), 32'd34);
            last_done = cyc;
        end
    end

    // Single operation with latency, busy-length and hold checks; called at posedge+1.
    task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_b,
                           input logic [31:0] er, input logic eo);
        int n;
        int nbusy;
        bit seen;
        a = ta;
        b = tb_b;
        start = 1'b1;
        push_exp(er, eo);
        @(posedge clock);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        nbusy = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clock);
            n++;
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_latency", 32'(n), 32'd33);
        check("busy_cycles", 32'(nbusy), 32'd33);
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("result_hold", result, er);
        check("overflow_hold", 32'(overflow), 32'(eo));
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with start asserted: reset must win.
        reset_n = 1'b0;
        start   = 1'b1;
        a       = 32'h00020000;
        b       = 32'h00030000;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;

        // First start accepted on the first edge out of reset.
        for (int i = 0; i < NV; i++) run_one(va[i], vb[i], vr[i], vo[i]);

        // Abort at CALC iteration 10.
        a = 32'h00020000;
        b = 32'h00030000;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        run_one(32'h00010000, 32'h00010000, 32'h00010000, 1'b0);

        // Start held high with operands scrambled outside each acceptance edge.
        period_chk = 1'b1;
        last_done  = -1;
        start = 1'b1;
        for (int i = NV - 1; i >= NV - 6; i--) begin
            a = va[i];
            b = vb[i];
            push_exp(vr[i], vo[i]);
            @(posedge clock);
            #1;
            repeat (33) begin
                a = $urandom;
                b = $urandom;
                @(posedge clock);
                #1;
            end
        end
        start = 1'b0;
        for (int n = 0; n < 80 && sb.size() != 0; n++) @(negedge clock);
        repeat (40) @(negedge clock);
        period_chk = 1'b0;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
